// File: rtl/stack_unit_p.sv
// stack_unit_p: signed stack processor with a handshaked request interface.
// Its multicycle MEAN op accumulates the popped words, then divides by restoring division.
module stack_unit_p #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int NW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             rdy_in,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] datain,
    input  logic [NW-1:0]    n,
    output logic [WIDTH-1:0] dataout,
    output logic             esito,
    output logic             ack,
    output logic             busy,
    output logic [NW-1:0]    count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int L  = WIDTH + NW;
    localparam int CW = $clog2(L + 1);
    localparam logic [NW-1:0] DMAX = NW'(DEPTH);

    typedef enum logic [2:0] {IDLE, EXEC, ACC, DIV, DONE} state_t;

    state_t            state;
    logic [2:0]        lop;
    logic [WIDTH-1:0]  ldat;
    logic [NW-1:0]     ln, left, rem, cnt_ex;
    logic              lrdy, neg, ok, fits, we0, we1;
    logic [L-1:0]      acc, acc_nx, dvd;
    logic [NW:0]       rem_sh;
    logic [CW-1:0]     steps;
    logic [WIDTH-1:0]  stk [DEPTH];
    logic [WIDTH-1:0]  top, sec, res, qw, wd0;
    logic [AW-1:0]     ti, si, wi, wa0;

    function automatic logic legal(input logic [2:0] o, input logic [NW-1:0] c, input logic [NW-1:0] k);
        return (o == 3'd0) ? c < DMAX :
               (o == 3'd1) ? c != '0 :
               (o == 3'd4) ? (k != '0 && k <= c) :
               (o == 3'd5) ? (c != '0 && c < DMAX) :
               (o == 3'd7) ? 1'b1 : c >= NW'(2);
    endfunction

    assign ti     = AW'(count - NW'(1));
    assign si     = AW'(count - NW'(2));
    assign wi     = AW'(count);
    assign top    = stk[ti];
    assign sec    = stk[si];
    assign ok     = legal(lop, count, ln);
    assign acc_nx = acc + {{NW{top[WIDTH-1]}}, top};
    assign rem_sh = {rem, dvd[L-1]};
    assign fits   = rem_sh >= {1'b0, ln};
    assign qw     = neg ? -dvd[WIDTH-1:0] : dvd[WIDTH-1:0];

    always_comb begin
        res    = lop == 3'd0 ? ldat : lop == 3'd2 ? top + sec : lop == 3'd3 ? top - sec :
                 lop == 3'd6 ? sec : lop == 3'd7 ? '0 : top;
        cnt_ex = (lop == 3'd0 || lop == 3'd5) ? count + NW'(1) : lop == 3'd7 ? '0 :
                 lop == 3'd6 ? count : count - NW'(1);
        we0    = state == DONE || (state == EXEC && ok && lop inside {3'd0, 3'd2, 3'd3, 3'd5, 3'd6});
        we1    = state == EXEC && ok && lop == 3'd6;
        wa0    = state == DONE ? wi : (lop == 3'd2 || lop == 3'd3) ? si : lop == 3'd6 ? ti : wi;
        wd0    = state == DONE ? qw : res;
    end

    // Storage is never reset; count alone defines which entries are live.
    always_ff @(posedge clock) begin
        if (we0) stk[wa0] <= wd0;
        if (we1) stk[si] <= top;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            dataout <= '0;
            esito   <= 1'b0;
            ack     <= 1'b0;
            busy    <= 1'b0;
            count   <= '0;
            lop     <= '0;
            ldat    <= '0;
            ln      <= '0;
            left    <= '0;
            lrdy    <= 1'b0;
            acc     <= '0;
            dvd     <= '0;
            rem     <= '0;
            neg     <= 1'b0;
            steps   <= '0;
        end else begin
            case (state)
                IDLE: if (rdy_in != ack) begin
                    lop   <= op;
                    ldat  <= datain;
                    ln    <= n;
                    left  <= n;
                    lrdy  <= rdy_in;
                    acc   <= '0;
                    busy  <= 1'b1;
                    state <= (op == 3'd4 && legal(op, count, n)) ? ACC : EXEC;
                end
                EXEC: begin
                    dataout <= ok ? res : dataout;
                    count   <= ok ? cnt_ex : count;
                    esito   <= ok;
                    ack     <= lrdy;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                ACC: begin
                    acc   <= acc_nx;
                    count <= count - NW'(1);
                    left  <= left - NW'(1);
                    if (left == NW'(1)) begin
                        dvd   <= acc_nx[L-1] ? -acc_nx : acc_nx;
                        neg   <= acc_nx[L-1];
                        rem   <= '0;
                        steps <= CW'(L);
                        state <= DIV;
                    end
                end
                DIV: begin
                    rem   <= NW'(fits ? rem_sh - {1'b0, ln} : rem_sh);
                    dvd   <= {dvd[L-2:0], fits};
                    steps <= steps - CW'(1);
                    if (steps == CW'(1)) state <= DONE;
                end
                default: begin
                    count   <= count + NW'(1);
                    dataout <= qw;
                    esito   <= 1'b1;
                    ack     <= lrdy;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stack_unit_p.sv
// tb_stack_unit_p: directed vector table, model-checked random ops, and an
// asynchronous reset during the division phase of a MEAN.
module tb_stack_unit_p;
    localparam int W = 32, D = 4, NWP = $clog2(D + 1), L = W + NWP;

    logic clock = 0, reset_n = 0, rdy_in = 0;
    logic [2:0] op = 0;
    logic [W-1:0] datain = 0;
    logic [NWP-1:0] n = 0;
    logic [W-1:0] dataout;
    logic esito, ack, busy;
    logic [NWP-1:0] count;

    stack_unit_p #(.WIDTH(W), .DEPTH(D)) dut (
        .clock(clock), .reset_n(reset_n), .rdy_in(rdy_in), .op(op), .datain(datain), .n(n),
        .dataout(dataout), .esito(esito), .ack(ack), .busy(busy), .count(count)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    int stk_m[$];
    logic [W-1:0] last_out = 0;

    typedef struct {
        logic [2:0] op; logic [W-1:0] d; logic [NWP-1:0] n;
        logic [W-1:0] out; logic ok; int cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic add(input logic [2:0] o, input logic [W-1:0] d, input logic [NWP-1:0] nn,
                       input logic [W-1:0] eo, input logic eok, input int ec);
        vec_t v;
        v.op = o; v.d = d; v.n = nn; v.out = eo; v.ok = eok; v.cnt = ec;
        tbl.push_back(v);
    endtask

    // One request: toggle rdy_in, scramble operands after acceptance, then wait (bounded) for ack.
    task automatic req(input logic [2:0] o, input logic [W-1:0] d, input logic [NWP-1:0] nn,
                       input logic [W-1:0] eo, input logic eok, input int ec, input string nm);
        int e, lat;
        lat = (o == 3'd4 && eok) ? int'(nn) + L + 2 : 2;
        @(negedge clock);
        op = o; datain = d; n = nn; rdy_in = ~rdy_in;
        for (e = 1; e <= 200; e++) begin
            @(posedge clock); #1;
            if (e == 1) begin
                chk({nm, " busy"}, 64'(busy), 64'd1);
                op = o ^ 3'd5; datain = ~d; n = ~nn;
            end
            if (ack == rdy_in) break;
        end
        chk({nm, " latency"}, 64'(e), 64'(lat));
        chk({nm, " dataout"}, 64'(dataout), 64'(eo));
        chk({nm, " esito"}, 64'(esito), 64'(eok));
        chk({nm, " count"}, 64'(count), 64'(ec));
        chk({nm, " busy_end"}, 64'(busy), 64'd0);
    endtask

    task automatic model(input logic [2:0] o, input logic [W-1:0] d, input logic [NWP-1:0] nn,
                         output logic [W-1:0] eo, output logic eok);
        int sz, t, s;
        longint sum;
        logic [W-1:0] r;
        sz = stk_m.size();
        r = 0;
        case (o)
            3'd0: begin eok = sz < D; if (eok) begin stk_m.push_back(int'(d)); r = d; end end
            3'd1: begin eok = sz >= 1; if (eok) r = stk_m.pop_back(); end
            3'd2, 3'd3: begin
                eok = sz >= 2;
                if (eok) begin
                    t = stk_m.pop_back(); s = stk_m.pop_back();
                    r = (o == 3'd2) ? t + s : t - s;
                    stk_m.push_back(int'(r));
                end
            end
            3'd4: begin
                eok = nn >= 1 && int'(nn) <= sz;
                if (eok) begin
                    sum = 0;
                    for (int i = 0; i < int'(nn); i++) sum += longint'(stk_m.pop_back());
                    r = W'(sum / longint'(nn));
                    stk_m.push_back(int'(r));
                end
            end
            3'd5: begin eok = sz >= 1 && sz < D; if (eok) begin r = stk_m[sz-1]; stk_m.push_back(int'(r)); end end
            3'd6: begin
                eok = sz >= 2;
                if (eok) begin
                    t = stk_m[sz-1]; stk_m[sz-1] = stk_m[sz-2]; stk_m[sz-2] = t;
                    r = stk_m[sz-1];
                end
            end
            default: begin eok = 1; stk_m.delete(); r = 0; end
        endcase
        if (eok) last_out = r;
        eo = last_out;
    endtask

    task automatic mreq(input logic [2:0] o, input logic [W-1:0] d, input logic [NWP-1:0] nn, input string nm);
        logic [W-1:0] eo;
        logic eok;
        model(o, d, nn, eo, eok);
        req(o, d, nn, eo, eok, stk_m.size(), nm);
    endtask

    initial begin
        logic [2:0] o;
        logic [W-1:0] d;
        add(0, 1023, 0, 1023, 1, 1);  add(1, 0, 0, 1023, 1, 0);  add(1, 0, 0, 1023, 0, 0);
        add(0, 500, 0, 500, 1, 1);    add(0, 750, 0, 750, 1, 2);  add(2, 0, 0, 1250, 1, 1);
        add(0, 500, 0, 500, 1, 2);    add(3, 0, 0, -32'sd750, 1, 1); add(7, 0, 0, 0, 1, 0);
        add(0, 500, 0, 500, 1, 1);    add(0, 750, 0, 750, 1, 2);  add(0, 1200, 0, 1200, 1, 3);
        add(0, 300, 0, 300, 1, 4);    add(0, 9, 0, 300, 0, 4);    add(4, 0, 0, 300, 0, 4);
        add(4, 0, 5, 300, 0, 4);      add(4, 0, 4, 687, 1, 1);    add(7, 0, 0, 0, 1, 0);
        add(0, -32'sd7, 0, -32'sd7, 1, 1); add(0, 0, 0, 0, 1, 2); add(4, 0, 2, -32'sd3, 1, 1);
        add(7, 0, 0, 0, 1, 0);        add(0, 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 1, 1);
        add(0, 1, 0, 1, 1, 2);        add(2, 0, 0, 32'h80000000, 1, 1);
        add(5, 0, 0, 32'h80000000, 1, 2); add(0, 5, 0, 5, 1, 3);  add(6, 0, 0, 32'h80000000, 1, 3);
        add(1, 0, 0, 32'h80000000, 1, 2); add(1, 0, 0, 5, 1, 1);  add(7, 0, 0, 0, 1, 0);
        add(5, 0, 0, 0, 0, 0);        add(0, 3, 0, 3, 1, 1);      add(2, 0, 0, 3, 0, 1);
        add(6, 0, 0, 3, 0, 1);        add(1, 0, 0, 3, 1, 0);

        repeat (2) @(posedge clock);
        #1;
        chk("reset dataout", 64'(dataout), 0);
        chk("reset esito", 64'(esito), 0);
        chk("reset ack", 64'(ack), 0);
        chk("reset busy", 64'(busy), 0);
        chk("reset count", 64'(count), 0);
        @(negedge clock) reset_n = 1;

        foreach (tbl[i])
            req(tbl[i].op, tbl[i].d, tbl[i].n, tbl[i].out, tbl[i].ok, tbl[i].cnt, $sformatf("vec%0d", i));

        last_out = 32'd3;
        for (int i = 0; i < 200; i++) begin
            o = 3'($urandom_range(0, 7));
            if (o == 3'd7 && $urandom_range(0, 3) != 0) o = 3'd0;
            d = ($urandom_range(0, 1) == 1) ? $urandom : W'($urandom_range(0, 2000)) - 32'd1000;
            mreq(o, d, 3'($urandom_range(0, 5)), $sformatf("rnd%0d", i));
        end

        mreq(7, 0, 0, "pre clear");
        mreq(0, 100, 0, "pre push a");
        mreq(0, 200, 0, "pre push b");
        @(negedge clock);
        op = 3'd4; n = 2; rdy_in = ~rdy_in;
        repeat (8) @(posedge clock);
        #2 reset_n = 0;
        #1;
        chk("abort dataout", 64'(dataout), 0);
        chk("abort esito", 64'(esito), 0);
        chk("abort ack", 64'(ack), 0);
        chk("abort busy", 64'(busy), 0);
        chk("abort count", 64'(count), 0);
        rdy_in = 1; op = 3'd0; datain = 42; n = 0;
        @(negedge clock) reset_n = 1;
        @(posedge clock); #1;
        chk("post busy", 64'(busy), 1);
        chk("post ack early", 64'(ack), 0);
        @(posedge clock); #1;
        chk("post ack", 64'(ack), 1);
        chk("post dataout", 64'(dataout), 42);
        chk("post esito", 64'(esito), 1);
        chk("post count", 64'(count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stack_unit_p.md
# stack_unit_p

Parametrised signed stack processor, successor to the fixed 32-bit STACK unit. Holds up to DEPTH signed WIDTH-bit words and executes eight stack operations, including a multicycle mean of the top n entries. Requests use the same transition-signalled handshake (rdy_in/ack) with a success flag (esito). It sits behind a single requester and returns the operation result on dataout.

## Interface
- WIDTH, 32: data word width; signed two's complement.
- DEPTH, 1024: maximum number of stored words; ≥ 2.
- NW, $clog2(DEPTH+1): width of n and count.
- clock  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rdy_in  in  1  transition-signalled request; a request is pending while rdy_in != ack.
- op  in  3  0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 MEAN, 5 DUP, 6 SWAP, 7 CLEAR.
- datain  in  WIDTH  operand for PUSH.
- n  in  NW  element count for MEAN.
- dataout  out  WIDTH  signed result of the last completed operation.
- esito  out  1  1 = last operation succeeded; 0 = rejected.
- ack  out  1  toggled to equal rdy_in on completion.
- busy  out  1  high from acceptance until completion.
- count  out  NW  current number of stored words.

## Operation
- Reset values: dataout 0, esito 0, ack 0, busy 0, count 0. State is IDLE and the stack is empty.
- FSM states: IDLE, EXEC, ACC, DIV, DONE.
- IDLE: on an edge where rdy_in != ack:
  - latch op, datain and n;
  - set busy;
  - go to ACC if the op is a legal MEAN, otherwise EXEC.
- Legality; an illegal op goes to EXEC as a reject:
  - PUSH and DUP need count < DEPTH, and DUP also needs count ≥ 1.
  - POP needs count ≥ 1.
  - ADD, SUB and SWAP need count ≥ 2.
  - MEAN needs 1 ≤ n ≤ count.
  - CLEAR is always legal.
- EXEC, legal op (T = top, S = second):
  - PUSH: push datain; dataout = datain.
  - POP: remove T; dataout = T.
  - ADD: pop T and S, push T+S.
  - SUB: pop T and S, push T−S.
  - DUP: push T; dataout = T.
  - SWAP: exchange T and S; dataout = new top.
  - CLEAR: count = 0; dataout = 0.
  - In all cases esito = 1, ack = latched rdy_in, busy = 0, return to IDLE.
- EXEC, reject: stack and dataout unchanged; esito = 0; ack toggles; return to IDLE.
- ADD and SUB wrap modulo 2^WIDTH; there is no saturation and no overflow flag.
- MEAN:
  - ACC: pop one word per cycle for n cycles, sign-extending each into a (WIDTH+NW)-bit accumulator.
  - DIV: restoring division of |sum| by n, one quotient bit per cycle, for WIDTH+NW cycles. The quotient is negated if the sum was negative, so the result truncates toward zero.
  - DONE: push the low WIDTH bits of the quotient; dataout = quotient; esito = 1; ack toggles.
- The requester must not toggle rdy_in while rdy_in != ack. Toggles during busy are neither detected nor queued.
- op, datain and n are sampled only at acceptance; later changes are ignored.
- Asynchronous reset mid-operation: the operation is aborted, the stack is emptied and all outputs return to their reset values. If rdy_in = 1 at release, a new request is pending and is accepted on the first edge after release.

## Timing
- Acceptance at edge k: busy = 1 after edge k.
- Non-MEAN ops, including all rejects: ack, esito, dataout and count update at edge k+1, so latency is 2 edges.
- MEAN: ACC covers edges k+1..k+n, DIV covers k+n+1..k+n+WIDTH+NW, and DONE updates the outputs at edge k+n+WIDTH+NW+1.
- count is stable between operations. During ACC it decrements one per edge, and the final value is count−n+1 after DONE.
- A new request is accepted no earlier than the first edge after ack toggles; one operation is in flight at a time.
- Stack storage is a register array or RAM indexed by count, with no wrap-around. Full and empty conditions are handled by rejection only.

## Test plan
- PUSH 1023 (rdy 0→1), then POP (rdy 1→0) → dataout 1023, esito 1, count 0, each ack toggling 2 edges after acceptance.
- PUSH 500, PUSH 750, ADD → dataout 1250, count 1. Then PUSH 500 and SUB → 500−1250 = −750, count 1.
- PUSH 500, 750, 1200 and 300, then MEAN n=4 → dataout 687, count 1, ack at edge k+4+WIDTH+NW+1. PUSH −7, PUSH 0, MEAN n=2 → −3 (truncation toward zero).
- Error cases:
  - POP on empty → esito 0, dataout unchanged.
  - With DEPTH=4, the fifth PUSH → esito 0, count 4.
  - MEAN with n=0 or n>count → esito 0, stack unchanged.
- ADD of 0x7FFFFFFF and 1 (WIDTH=32) → 0x80000000, esito 1. DUP, SWAP and CLEAR each return the documented dataout and count.
- Assert reset_n low during DIV of a MEAN → outputs go to 0 immediately and count is 0. With rdy_in held at 1, a new request is accepted on the first edge after release.
